// File: rtl/sub_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : sub_pkg
//  Description : Shared types and helpers for the digit-serial subtractor:
//                controller state encoding and a parameter sanity check.
//  Revision    : 1.0 - initial release
// ============================================================================
package sub_pkg;

  // Controller states, explicitly 2 bits wide
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // True when the operand width splits into a whole number of digits
  function automatic bit width_ok(input int width, input int digit);
    return (width >= 1) && (digit >= 1) && (digit <= width) &&
           ((width % digit) == 0);
  endfunction

endpackage
`default_nettype wire

// File: rtl/sub_digit.sv
`default_nettype none
// ============================================================================
//  Module      : sub_digit
//  Description : Combinational DIGIT-bit subtract slice, built as a ripple of
//                full-subtract cells. d = x - y - bin, bout = borrow out.
//  Revision    : 1.0 - initial release
// ============================================================================
module sub_digit #(
  parameter int DIGIT = 2
) (
  input  logic [DIGIT-1:0] x,
  input  logic [DIGIT-1:0] y,
  input  logic             bin,
  output logic [DIGIT-1:0] d,
  output logic             bout
);

  // Borrow chain; bit DIGIT is the borrow leaving the slice
  logic [DIGIT:0] w_b;

  assign w_b[0] = bin;

  generate
    for (genvar i = 0; i < DIGIT; i++) begin : g_cell
      assign d[i]     = x[i] ^ y[i] ^ w_b[i];
      assign w_b[i+1] = (~x[i] & y[i]) | (~(x[i] ^ y[i]) & w_b[i]);
    end
  endgenerate

  assign bout = w_b[DIGIT];

endmodule
`default_nettype wire

// File: rtl/serial_sub.sv
`default_nettype none
// ============================================================================
//  Module      : serial_sub
//  Description : Digit-serial unsigned subtractor, diff = a - b mod 2^WIDTH,
//                DIGIT bits per cycle LSB first, valid/ready on both sides.
//                Build option SERIAL_SUB_SAT_EN: saturate to zero when a < b.
//  Revision    : 1.0 - initial release
// ============================================================================
module serial_sub
  import sub_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DIGIT = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             borrow,
  output logic             zero
);

  localparam int NDIG = WIDTH / DIGIT;
  localparam int CW   = (NDIG > 1) ? $clog2(NDIG) : 1;
  localparam logic [CW-1:0] C_LAST = CW'(NDIG - 1);

  generate
    if (!width_ok(WIDTH, DIGIT)) begin : g_bad_cfg
      $error("serial_sub: WIDTH must be a positive multiple of DIGIT");
    end
  endgenerate

  state_t           r_state;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic             r_bin;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_diff;
  logic             r_borrow;
  logic             r_zero;
  logic             r_out_valid;

  logic [DIGIT-1:0] w_d;
  logic             w_bout;
  logic [WIDTH-1:0] w_diff_next;

  sub_digit #(
    .DIGIT (DIGIT)
  ) u_digit (
    .x    (r_a[DIGIT-1:0]),
    .y    (r_b[DIGIT-1:0]),
    .bin  (r_bin),
    .d    (w_d),
    .bout (w_bout)
  );

  // New result digit enters at the MSB end; whole word when only one digit
  generate
    if (DIGIT == WIDTH) begin : g_single
      assign w_diff_next = w_d;
    end else begin : g_multi
      assign w_diff_next = {w_d, r_diff[WIDTH-1:DIGIT]};
    end
  endgenerate

  // Controller and datapath registers. out_valid rises one cycle after DONE
  // is entered so that the zero flag is taken from the registered diff
  // rather than from the end of the borrow chain.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_a         <= '0;
      r_b         <= '0;
      r_bin       <= 1'b0;
      r_cnt       <= '0;
      r_diff      <= '0;
      r_borrow    <= 1'b0;
      r_zero      <= 1'b0;
      r_out_valid <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_a     <= a;
            r_b     <= b;
            r_bin   <= 1'b0;
            r_cnt   <= '0;
            r_state <= RUN;
          end
        end
        RUN: begin
          r_a    <= r_a >> DIGIT;
          r_b    <= r_b >> DIGIT;
          r_bin  <= w_bout;
          r_diff <= w_diff_next;
          r_cnt  <= r_cnt + CW'(1);
          if (r_cnt == C_LAST) begin
            r_borrow <= w_bout;
            r_state  <= DONE;
          end
        end
        DONE: begin
          if (!r_out_valid) begin
            r_out_valid <= 1'b1;
`ifdef SERIAL_SUB_SAT_EN
            if (r_borrow) begin
              r_diff <= '0;
              r_zero <= 1'b1;
            end else begin
              r_zero <= (r_diff == '0);
            end
`else
            r_zero <= (r_diff == '0);
`endif
          end else if (out_ready) begin
            r_out_valid <= 1'b0;
            r_state     <= IDLE;
          end
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign in_ready  = (r_state == IDLE);
  assign out_valid = r_out_valid;
  assign diff      = r_diff;
  assign borrow    = r_borrow;
  assign zero      = r_zero;

endmodule
`default_nettype wire

// File: tb/tb_serial_sub.sv
`default_nettype none
// ============================================================================
//  Module      : tb_serial_sub
//  Description : Self-checking bench for serial_sub. Two instances:
//                WIDTH=8/DIGIT=2 (directed) and WIDTH=8/DIGIT=8 (random).
//                Honours SERIAL_SUB_SAT_EN in its reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_serial_sub;

  typedef struct packed {
    logic [7:0] diff;
    logic       borrow;
    logic       zero;
  } exp_t;

  logic       clk;
  logic       rst;

  logic       in_valid0, in_ready0, out_valid0, out_ready0;
  logic [7:0] a0, b0, diff0;
  logic       borrow0, zero0;

  logic       in_valid1, in_ready1, out_valid1, out_ready1;
  logic [7:0] a1, b1, diff1;
  logic       borrow1, zero1;

  int   total;
  int   bad;
  exp_t sb[$];

  serial_sub #(.WIDTH(8), .DIGIT(2)) u_dut0 (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid0),
    .in_ready  (in_ready0),
    .a         (a0),
    .b         (b0),
    .out_valid (out_valid0),
    .out_ready (out_ready0),
    .diff      (diff0),
    .borrow    (borrow0),
    .zero      (zero0)
  );

  serial_sub #(.WIDTH(8), .DIGIT(8)) u_dut1 (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid1),
    .in_ready  (in_ready1),
    .a         (a1),
    .b         (b1),
    .out_valid (out_valid1),
    .out_ready (out_ready1),
    .diff      (diff1),
    .borrow    (borrow1),
    .zero      (zero1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: 9-bit subtraction, top bit is the borrow
  function automatic exp_t model(input logic [7:0] x, input logic [7:0] y);
    exp_t       e;
    logic [8:0] t;
    t        = {1'b0, x} - {1'b0, y};
    e.diff   = t[7:0];
    e.borrow = t[8];
    e.zero   = (t[7:0] == 8'h00);
`ifdef SERIAL_SUB_SAT_EN
    if (e.borrow) begin
      e.diff = 8'h00;
      e.zero = 1'b1;
    end
`endif
    return e;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic get_ir(input bit sel);
    return sel ? in_ready1 : in_ready0;
  endfunction

  function automatic logic get_ov(input bit sel);
    return sel ? out_valid1 : out_valid0;
  endfunction

  // One operation: push expectation, handshake, measure latency, pop and
  // compare. With release set (and out_ready high) also checks the return
  // to IDLE one edge later.
  task automatic run_op(input bit sel, input logic [7:0] av, input logic [7:0] bv,
                        input bit release_chk);
    exp_t e;
    int   lat;
    logic [7:0] d;
    logic bo, z;
    sb.push_back(model(av, bv));
    chk("in_ready_before", 32'(get_ir(sel)), 32'd1);
    if (sel) begin in_valid1 = 1'b1; a1 = av; b1 = bv; end
    else     begin in_valid0 = 1'b1; a0 = av; b0 = bv; end
    @(posedge clk); #1;
    in_valid0 = 1'b0;
    in_valid1 = 1'b0;
    lat = 0;
    while (!get_ov(sel) && lat < 50) begin
      @(posedge clk); #1;
      lat++;
    end
    chk("latency", 32'(lat), sel ? 32'd2 : 32'd5);
    chk("out_valid", 32'(get_ov(sel)), 32'd1);
    chk("in_ready_busy", 32'(get_ir(sel)), 32'd0);
    e  = sb.pop_front();
    d  = sel ? diff1 : diff0;
    bo = sel ? borrow1 : borrow0;
    z  = sel ? zero1 : zero0;
    chk("diff", 32'(d), 32'(e.diff));
    chk("borrow", 32'(bo), 32'(e.borrow));
    chk("zero", 32'(z), 32'(e.zero));
    if (release_chk) begin
      @(posedge clk); #1;
      chk("idle_out_valid", 32'(get_ov(sel)), 32'd0);
      chk("idle_in_ready", 32'(get_ir(sel)), 32'd1);
    end
  endtask

  initial begin
    logic [7:0] hd;
    logic       hb, hz;
    total      = 0;
    bad        = 0;
    rst        = 1'b1;
    in_valid0  = 1'b0; a0 = '0; b0 = '0; out_ready0 = 1'b1;
    in_valid1  = 1'b0; a1 = '0; b1 = '0; out_ready1 = 1'b1;

    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready", 32'(in_ready0), 32'd1);
    chk("rst_out_valid", 32'(out_valid0), 32'd0);
    chk("rst_diff", 32'(diff0), 32'd0);
    chk("rst_borrow", 32'(borrow0), 32'd0);
    chk("rst_zero", 32'(zero0), 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Directed operations on the DIGIT=2 instance
    run_op(1'b0, 8'h5A, 8'h3C, 1'b1);
    run_op(1'b0, 8'h10, 8'h20, 1'b1);
    run_op(1'b0, 8'h00, 8'h01, 1'b1);
    run_op(1'b0, 8'hA5, 8'hA5, 1'b1);
    run_op(1'b0, 8'hFF, 8'h00, 1'b1);

    // Backpressure: result held in DONE, new operands ignored
    out_ready0 = 1'b0;
    run_op(1'b0, 8'h81, 8'h7F, 1'b0);
    hd = diff0; hb = borrow0; hz = zero0;
    for (int i = 0; i < 10; i++) begin
      in_valid0 = 1'b1; a0 = 8'h77; b0 = 8'h11;
      @(posedge clk); #1;
      chk("bp_out_valid", 32'(out_valid0), 32'd1);
      chk("bp_in_ready", 32'(in_ready0), 32'd0);
      chk("bp_diff", 32'(diff0), 32'(hd));
      chk("bp_borrow", 32'(borrow0), 32'(hb));
      chk("bp_zero", 32'(zero0), 32'(hz));
    end
    in_valid0  = 1'b0;
    out_ready0 = 1'b1;
    @(posedge clk); #1;
    chk("bp_rel_out_valid", 32'(out_valid0), 32'd0);
    chk("bp_rel_in_ready", 32'(in_ready0), 32'd1);
    @(posedge clk); #1;
    chk("bp_no_capture", 32'(in_ready0), 32'd1);

    // Reset during the second RUN cycle
    in_valid0 = 1'b1; a0 = 8'hC3; b0 = 8'h12;
    @(posedge clk); #1;
    in_valid0 = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("mid_rst_out_valid", 32'(out_valid0), 32'd0);
    chk("mid_rst_diff", 32'(diff0), 32'd0);
    chk("mid_rst_in_ready", 32'(in_ready0), 32'd1);
    chk("mid_rst_borrow", 32'(borrow0), 32'd0);
    run_op(1'b0, 8'h03, 8'h01, 1'b1);

    // DIGIT == WIDTH instance against the model with random operands
    for (int n = 0; n < 1000; n++) begin
      run_op(1'b1, 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), 1'b1);
    end

    chk("scoreboard_empty", 32'(sb.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
